alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder, plus the two ID/EX operands.
- Produces a registered result and flags for the EX/MEM register.
- Logic ops, add, subtract and set-less-than complete in one cycle.
- Multiply is an iterative shift-add over WIDTH cycles; `busy` stalls the pipeline front end for its duration.

---
 rtl/alu_exec_unit.sv | 150 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_exec_unit                                                 |
// | Purpose  : Execute-stage ALU; 1-cycle logic/arith/SLT, iterative MUL.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             done,
  output logic             busy
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_MUL  = 1'b1;

  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_OR  = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0110;
  localparam logic [3:0] c_OP_SLT = 4'b0111;
  localparam logic [3:0] c_OP_MUL = 4'b1000;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_illegal;
  logic             r_done;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_legal;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_acc_next;

  assign w_sum      = op_a + op_b;
  assign w_diff     = op_a - op_b;
  // Signed compare, not the sign of w_diff, so SLT stays right on overflow.
  assign w_slt      = $signed(op_a) < $signed(op_b);
  assign w_is_mul   = (alu_ctrl == c_OP_MUL);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_res   = '0;
    w_ovf   = 1'b0;
    w_legal = 1'b1;
    case (alu_ctrl)
      c_OP_AND: w_res = op_a & op_b;
      c_OP_OR:  w_res = op_a | op_b;
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      c_OP_MUL: w_res = '0;
      default:  w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start && !flush) begin
            if (w_is_mul) begin
              r_mcand  <= op_a;
              r_mplier <= op_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= c_MUL;
            end else begin
              // Illegal codes fall through with w_res=0 and w_ovf=0.
              r_result  <= w_res;
              r_zero    <= (w_res == '0);
              r_ovf     <= w_ovf;
              r_illegal <= ~w_legal;
              r_done    <= 1'b1;
            end
          end
        end
        c_MUL: begin
          if (flush) begin
            r_state <= c_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_result <= w_acc_next;
              r_zero   <= (w_acc_next == '0);
              r_ovf    <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= c_IDLE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign illegal  = r_illegal;
  assign done     = r_done;
  assign busy     = (r_state == c_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_exec_unit                                              |
// | Purpose  : Scoreboard bench for alu_exec_unit (WIDTH=32).                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_alu_exec_unit;

  localparam int c_W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic           flush;
  logic [3:0]     alu_ctrl;
  logic [c_W-1:0] op_a;
  logic [c_W-1:0] op_b;
  logic [c_W-1:0] result;
  logic           zero;
  logic           overflow;
  logic           illegal;
  logic           done;
  logic           busy;

  alu_exec_unit #(.WIDTH(c_W), .CNT_W(6)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .flush    (flush),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .illegal  (illegal),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    logic [c_W-1:0] res;
    logic           z;
    logic           ov;
    logic           il;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errs   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [c_W-1:0] a, input logic [c_W-1:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    e.ov = 1'b0;
    e.il = 1'b0;
    e.res = '0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: begin
        s = sa + sb;
        e.res = a + b;
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = sa - sb;
        e.res = a - b;
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1000: e.res = a * b;
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk_eq("unexpected_done", 64'(done), 64'd0);
      end else begin
        m_e = q.pop_front();
        chk_eq("sb_result",   64'(result),   64'(m_e.res));
        chk_eq("sb_zero",     64'(zero),     64'(m_e.z));
        chk_eq("sb_overflow", 64'(overflow), 64'(m_e.ov));
        chk_eq("sb_illegal",  64'(illegal),  64'(m_e.il));
      end
    end
  end

  // Drive one request just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic op(input logic [3:0] c, input logic [c_W-1:0] a, input logic [c_W-1:0] b, input bit exp_done);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    start    = 1'b1;
    if (exp_done) q.push_back(model(c, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [3:0] ctrls [5];
  int         n;
  int         bc;

  initial begin
    ctrls    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    rst      = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    alu_ctrl = 4'b0000;
    op_a     = '0;
    op_b     = '0;

    #12;
    chk_eq("rst_result",   64'(result),   64'd0);
    chk_eq("rst_zero",     64'(zero),     64'd1);
    chk_eq("rst_overflow", 64'(overflow), 64'd0);
    chk_eq("rst_illegal",  64'(illegal),  64'd0);
    chk_eq("rst_done",     64'(done),     64'd0);
    chk_eq("rst_busy",     64'(busy),     64'd0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD with signed overflow
    op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    chk_eq("add_done", 64'(done), 64'd1);
    chk_eq("add_busy", 64'(busy), 64'd0);
    chk_eq("add_ovf",  64'(overflow), 64'd1);

    // SUB then SLT back to back
    op(4'b0110, 32'd5, 32'd5, 1'b1);
    chk_eq("sub_done", 64'(done), 64'd1);
    chk_eq("sub_zero", 64'(zero), 64'd1);
    op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    chk_eq("slt_done",   64'(done),   64'd1);
    chk_eq("slt_result", 64'(result), 64'd1);

    // Overflowing SLT corner: most-negative vs positive
    op(4'b0111, 32'h8000_0000, 32'h0000_0001, 1'b1);
    op(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 8; i++) begin
      op(ctrls[$urandom_range(0, 4)], $urandom, $urandom, 1'b1);
    end

    // MUL latency and busy window
    op(4'b1000, 32'd12345, 32'd678, 1'b1);
    n  = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    chk_eq("mul_latency", 64'(n),      64'd32);
    chk_eq("mul_busy",    64'(bc),     64'd32);
    chk_eq("mul_result",  64'(result), 64'd8369910);
    chk_eq("mul_busy_end", 64'(busy),  64'd0);

    op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_eq("mulff_latency", 64'(n),      64'd32);
    chk_eq("mulff_result",  64'(result), 64'd1);

    // MUL aborted by flush on its 10th cycle, with an ADD held during busy
    op(4'b1000, 32'd3, 32'd5, 1'b0);
    alu_ctrl = 4'b0010;
    op_a     = 32'd1;
    op_b     = 32'd2;
    start    = 1'b1;
    for (int i = 1; i < 10; i++) begin
      chk_eq("flush_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk_eq("flush_busy_low", 64'(busy),   64'd0);
    chk_eq("flush_no_done",  64'(done),   64'd0);
    chk_eq("flush_result",   64'(result), 64'd1);
    chk_eq("flush_zero",     64'(zero),   64'd0);

    // Flush beats start in IDLE
    alu_ctrl = 4'b0010;
    op_a     = 32'd10;
    op_b     = 32'd20;
    start    = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk_eq("idle_flush_done",   64'(done),   64'd0);
    chk_eq("idle_flush_result", 64'(result), 64'd1);

    // Illegal opcode
    op(4'b0101, 32'h1234_5678, 32'h0000_00FF, 1'b1);
    chk_eq("ill_pulse", 64'(illegal), 64'd1);
    chk_eq("ill_zero",  64'(zero),    64'd1);
    @(posedge clk);
    #1;
    chk_eq("ill_one_cycle", 64'(illegal), 64'd0);

    // Value to be wiped by the async reset below
    op(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 1'b1);

    // Async reset in the middle of a multiply
    op(4'b1000, 32'd7, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_eq("amid_result",   64'(result),   64'd0);
    chk_eq("amid_zero",     64'(zero),     64'd1);
    chk_eq("amid_overflow", 64'(overflow), 64'd0);
    chk_eq("amid_busy",     64'(busy),     64'd0);
    chk_eq("amid_done",     64'(done),     64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk_eq("post_rst_busy", 64'(busy), 64'd0);

    op(4'b0010, 32'd2, 32'd3, 1'b1);
    chk_eq("post_rst_add", 64'(result), 64'd5);

    repeat (3) @(posedge clk);
    #1;
    chk_eq("sb_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
